// File: rtl/board_snapshot_tx.sv
// board_snapshot_tx
//   Dumps the life board as a byte stream: a header byte, then every board
//   row packed MSB-first, eight cells per byte. One row is captured from the
//   live pixel stream into a row buffer, drained over a valid/ready byte
//   port, then the next row is awaited. freeze_out is held for the whole
//   dump so the board does not evolve underneath it.
//
//   Optional feature macro: SNAP_CRC_EN
//     defined   - CRC-8 (poly 0x07, init 0x00) over all row bytes, sent as a
//                 trailing byte after the last row.
//     undefined - stream ends with the last row byte, no CRC logic.
module board_snapshot_tx #(
   parameter int         BOARD_W      = 64,
   parameter logic [7:0] HDR_BYTE     = 8'hA5,
   parameter int         HCOUNT_WIDTH = 11,
   parameter int         VCOUNT_WIDTH = 10
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    start_in,
   input  logic [HCOUNT_WIDTH-1:0] hcount_in,
   input  logic [VCOUNT_WIDTH-1:0] vcount_in,
   input  logic                    alive_in,
   output logic [7:0]              byte_out,
   output logic                    byte_valid_out,
   input  logic                    byte_ready_in,
   output logic                    busy_out,
   output logic                    freeze_out,
   output logic                    done_out
);

   localparam int NB  = BOARD_W / 8;                 // bytes per row
   localparam int RW  = $clog2(BOARD_W) + 1;         // row index width
   localparam int BW  = $clog2(NB) + 1;              // byte index width
   localparam int BIW = (NB > 1) ? $clog2(NB) : 1;   // row buffer select width
   localparam int MW0 = (HCOUNT_WIDTH > VCOUNT_WIDTH) ? HCOUNT_WIDTH : VCOUNT_WIDTH;
   localparam int XW  = ((MW0 > RW) ? MW0 : RW) + 1; // common compare width

`ifdef SNAP_CRC_EN
   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_WAIT_ROW, S_CAPTURE, S_DRAIN, S_TRAILER, S_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_WAIT_ROW, S_CAPTURE, S_DRAIN, S_DONE
   } state_t;
`endif

   state_t               state_q, state_d;
   logic [RW-1:0]        row_idx;
   logic [BW-1:0]        byte_idx;
   logic [6:0]           shift_q;
   logic [NB-1:0][7:0]   row_buf;

   // Coordinates widened to one width so all compares are like-for-like.
   logic [XW-1:0]        hx, vy, ry;
   logic                 on_row, row_start, row_end;
   logic                 xfer, last_byte, last_row;
   logic [BIW-1:0]       rd_sel, wr_sel;

   assign hx = XW'(hcount_in);
   assign vy = XW'(vcount_in);
   assign ry = XW'(row_idx);

   // A pixel belongs to the row being captured only if it is on the board
   // and on the current row; anything else is ignored.
   assign on_row    = (vy == ry) && (hx < XW'(BOARD_W));
   assign row_start = on_row && (hx == '0);
   assign row_end   = on_row && (hx == XW'(BOARD_W - 1));

   assign xfer      = byte_valid_out && byte_ready_in;
   assign last_byte = (byte_idx == BW'(NB - 1));
   assign last_row  = (row_idx == RW'(BOARD_W - 1));

   assign rd_sel    = byte_idx[BIW-1:0];
   assign wr_sel    = hx[BIW+2:3];

`ifdef SNAP_CRC_EN
   logic [7:0] crc_q;

   // One CRC-8 step over a whole byte, MSB first.
   function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      r = c ^ d;
      for (int i = 0; i < 8; i++)
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction
`endif

   // State register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (start_in)  state_d = S_HEADER;
         S_HEADER:   if (xfer)      state_d = S_WAIT_ROW;
         S_WAIT_ROW: if (row_start) state_d = S_CAPTURE;
         S_CAPTURE:  if (row_end)   state_d = S_DRAIN;
         S_DRAIN: begin
            if (xfer && last_byte) begin
`ifdef SNAP_CRC_EN
               state_d = last_row ? S_TRAILER : S_WAIT_ROW;
`else
               state_d = last_row ? S_DONE : S_WAIT_ROW;
`endif
            end
         end
`ifdef SNAP_CRC_EN
         S_TRAILER:  if (xfer)      state_d = S_DONE;
`endif
         S_DONE:                    state_d = S_IDLE;
         default:                   state_d = S_IDLE;
      endcase
   end

   // Output decode: byte offer is a pure function of state and held
   // registers, so it stays stable for as long as ready is low.
   always_comb begin
      byte_out       = 8'h00;
      byte_valid_out = 1'b0;
      busy_out       = (state_q != S_IDLE);
      freeze_out     = (state_q != S_IDLE);
      done_out       = (state_q == S_DONE);
      case (state_q)
         S_HEADER: begin
            byte_out       = HDR_BYTE;
            byte_valid_out = 1'b1;
         end
         S_DRAIN: begin
            byte_out       = row_buf[rd_sel];
            byte_valid_out = 1'b1;
         end
`ifdef SNAP_CRC_EN
         S_TRAILER: begin
            byte_out       = crc_q;
            byte_valid_out = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // Row and byte counters.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         row_idx  <= '0;
         byte_idx <= '0;
      end else begin
         case (state_q)
            S_IDLE:    if (start_in) begin
               row_idx  <= '0;
               byte_idx <= '0;
            end
            S_CAPTURE: if (row_end) byte_idx <= '0;
            S_DRAIN:   if (xfer) begin
               if (last_byte) begin
                  byte_idx <= '0;
                  row_idx  <= row_idx + 1'b1;
               end else begin
                  byte_idx <= byte_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Cell shift register: holds the first seven cells of the byte being
   // assembled; x=8k ends up in the MSB once the eighth cell arrives.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         shift_q <= '0;
      end else if (state_q == S_WAIT_ROW && row_start) begin
         shift_q <= {6'b0, alive_in};
      end else if (state_q == S_CAPTURE && on_row) begin
         shift_q <= {shift_q[5:0], alive_in};
      end
   end

   // Row buffer: written once per eight cells, contents need no reset.
   always_ff @(posedge clk_in) begin
      if (state_q == S_CAPTURE && on_row && hx[2:0] == 3'd7)
         row_buf[wr_sel] <= {shift_q, alive_in};
   end

`ifdef SNAP_CRC_EN
   // CRC accumulates only row bytes as they are accepted.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)                          crc_q <= 8'h00;
      else if (state_q == S_IDLE && start_in) crc_q <= 8'h00;
      else if (state_q == S_DRAIN && xfer)    crc_q <= crc8_next(crc_q, byte_out);
   end
`endif

endmodule

// File: tb/tb_board_snapshot_tx.sv
// Bench for board_snapshot_tx with a 16x16 board (2 bytes/row).
module tb_board_snapshot_tx;

   localparam int BW   = 16;
   localparam int HTOT = 20;
   localparam int VTOT = 18;

   logic       clk, rst_n, start, alive, ready;
   logic [5:0] hcount, vcount;
   logic [7:0] byte_out;
   logic       valid, busy, freeze, done;

   board_snapshot_tx #(.BOARD_W(BW), .HDR_BYTE(8'hA5), .HCOUNT_WIDTH(6), .VCOUNT_WIDTH(6)) dut (
      .clk_in(clk), .rst_in(rst_n), .start_in(start),
      .hcount_in(hcount), .vcount_in(vcount), .alive_in(alive),
      .byte_out(byte_out), .byte_valid_out(valid), .byte_ready_in(ready),
      .busy_out(busy), .freeze_out(freeze), .done_out(done)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   bit         board[BW][BW];   // [y][x]
   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int         n_chk  = 0;
   int         n_pass = 0;

   // Raster scan: free-running pixel stream, off-board pixels carry noise.
   initial begin
      hcount = 0; vcount = 0; alive = 0;
      forever begin
         @(posedge clk); #1;
         if (hcount == HTOT - 1) begin
            hcount = 0;
            vcount = (vcount == VTOT - 1) ? 6'd0 : vcount + 6'd1;
         end else begin
            hcount = hcount + 6'd1;
         end
         if (hcount < BW && vcount < BW) alive = board[vcount][hcount];
         else                            alive = 1'($urandom_range(0, 1));
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Reference CRC: shift the dividend bit by bit through the register.
   function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
      logic fb;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ d[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return c;
   endfunction

   // Expected stream straight from the board picture.
   task automatic build_exp();
      logic [7:0] b, crc;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      crc = 8'h00;
      for (int y = 0; y < BW; y++)
         for (int k = 0; k < BW / 8; k++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++)
               if (board[y][8 * k + j]) b = b | (8'h80 >> j);
            exp_q.push_back(b);
            crc = crc_ref(crc, b);
         end
`ifdef SNAP_CRC_EN
      exp_q.push_back(crc);
`endif
   endtask

   task automatic clear_board();
      for (int y = 0; y < BW; y++)
         for (int x = 0; x < BW; x++) board[y][x] = 0;
   endtask

   task automatic cmp_stream(input string tag);
      int n;
      chk({tag, " length"}, got.size(), exp_q.size());
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s byte[%0d]", tag, i), got[i], exp_q[i]);
   endtask

   // One snapshot; called and left at a negedge with the DUT idle.
   task automatic run_snap(input string tag, input int stall_at, input int stall_len,
                           input int busy_at, input bit done_start, input bit rnd_ready,
                           input int abort_at, output bit aborted);
      int cyc = 0, stall_left = 0, freeze_bad = 0, hold_bad = 0, ndone = 0;
      bit fin = 0, stalled = 0;
      logic [7:0] hold_b = 8'h00;
      got.delete();
      aborted = 0;
      @(posedge clk); #1 start = 1; ready = 1;
      @(posedge clk); #1 start = 0;
      @(negedge clk);
      chk({tag, " busy/freeze after start"}, {busy, freeze}, 2'b11);
      while (!fin && cyc < 20000) begin
         if (!freeze) freeze_bad++;
         if (stall_left > 0 && (!valid || byte_out !== hold_b)) hold_bad++;
         if (valid && ready) got.push_back(byte_out);
         if (abort_at >= 0 && got.size() == abort_at && valid) begin
            #1 rst_n = 0;
            #1 chk({tag, " async reset outputs"}, {valid, busy, freeze, done}, 4'b0000);
            @(negedge clk);
            chk({tag, " reset held outputs"}, {valid, busy, freeze, done}, 4'b0000);
            rst_n = 1;
            aborted = 1;
            return;
         end
         if (done) begin
            ndone++;
            if (done_start) start = 1;
            fin = 1;
         end
         @(posedge clk); #1 start = 0;
         if (stall_left > 0) stall_left--;
         if (!stalled && stall_at >= 0 && got.size() == stall_at) begin
            stalled    = 1;
            stall_left = stall_len;
            hold_b     = byte_out;
         end
         ready = (stall_left > 0) ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
         if (cyc == busy_at) start = 1;
         cyc++;
         @(negedge clk);
      end
      chk({tag, " completed in budget"}, fin, 1'b1);
      chk({tag, " done pulses"}, ndone, 1);
      chk({tag, " freeze held"}, freeze_bad, 0);
      if (stall_at >= 0) begin
         chk({tag, " stall reached"}, stalled, 1'b1);
         chk({tag, " offer stable in stall"}, hold_bad, 0);
      end
      chk({tag, " idle after done"}, {busy, freeze, done}, 3'b000);
      @(posedge clk); @(negedge clk);
      chk({tag, " still idle"}, {busy, freeze}, 2'b00);
      cmp_stream(tag);
   endtask

   typedef struct {
      int         x0, y0, x1, y1;        // live cells (-1 = none)
      int         stall_at, stall_len;
      int         busy_at;
      bit         done_start;
      int         si0;  logic [7:0] sv0; // spot checks from the cell layout
      int         si1;  logic [7:0] sv1;
   } vec_t;

   vec_t vt[6];

   initial begin
      bit ab;
      vt[0] = '{0, 0, -1, -1, -1, 0, -1, 1'b0, 1, 8'h80, 0, 8'hA5};
      vt[1] = '{15, 15, -1, -1, -1, 0, -1, 1'b0, 32, 8'h01, 31, 8'h00};
      vt[2] = '{7, 2, 8, 2, -1, 0, -1, 1'b0, 5, 8'h01, 6, 8'h80};
      vt[3] = '{3, 3, 12, 4, 8, 10, -1, 1'b0, 7, 8'h10, 10, 8'h08};
      vt[4] = '{5, 9, -1, -1, -1, 0, 40, 1'b1, 19, 8'h04, 0, 8'hA5};
      vt[5] = '{-1, -1, -1, -1, -1, 0, -1, 1'b0, 1, 8'h00, 32, 8'h00};

      rst_n = 0; start = 0; ready = 0;
      clear_board();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset outputs", {byte_out, valid, busy, freeze, done}, 12'h000);
      rst_n = 1;
      @(negedge clk);
      chk("idle after reset", {byte_out, valid, busy, freeze, done}, 12'h000);

      for (int i = 0; i < 6; i++) begin
         clear_board();
         if (vt[i].x0 >= 0) board[vt[i].y0][vt[i].x0] = 1;
         if (vt[i].x1 >= 0) board[vt[i].y1][vt[i].x1] = 1;
         build_exp();
         run_snap($sformatf("vec%0d", i), vt[i].stall_at, vt[i].stall_len,
                  vt[i].busy_at, vt[i].done_start, 1'b0, -1, ab);
         if (got.size() > vt[i].si0) chk($sformatf("vec%0d spot0", i), got[vt[i].si0], vt[i].sv0);
         else chk($sformatf("vec%0d spot0 present", i), got.size(), vt[i].si0 + 1);
         if (got.size() > vt[i].si1) chk($sformatf("vec%0d spot1", i), got[vt[i].si1], vt[i].sv1);
         else chk($sformatf("vec%0d spot1 present", i), got.size(), vt[i].si1 + 1);
      end

`ifdef SNAP_CRC_EN
      // vt[5] was the all-dead board: 34 bytes with a zero trailer.
      chk("dead board crc length", got.size(), 34);
      if (got.size() == 34) chk("dead board trailer", got[33], 8'h00);
`endif

      // Randomized boards with a random sink.
      for (int r = 0; r < 3; r++) begin
         for (int y = 0; y < BW; y++)
            for (int x = 0; x < BW; x++) board[y][x] = ($urandom_range(0, 3) == 0);
         build_exp();
         run_snap($sformatf("rand%0d", r), -1, 0, -1, 1'b0, 1'b1, -1, ab);
      end

      // Reset mid-drain, then a fresh snapshot from the top.
      clear_board();
      board[0][0] = 1;
      board[2][9] = 1;
      build_exp();
      run_snap("abort", -1, 0, -1, 1'b0, 1'b0, 5, ab);
      chk("abort happened", ab, 1'b1);
      @(negedge clk);
      run_snap("after abort", -1, 0, -1, 1'b0, 1'b1, -1, ab);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
